z480_int_alu_pipe: RTL

Z480_INT_ALU_PIPE -- requirements
Module: z480_int_alu_pipe

---
 rtl/z480_int_alu_pipe.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/z480_int_alu_pipe.sv
// Pipelined integer ALU: result computed at issue, carried with its tags through STAGES registers.
// Optional feature: define Z480_INT_ALU_FLAGS_EN to produce {V,C,N,Z} on wb_flags[3:0].
module z480_int_alu_pipe #(
  parameter int XLEN   = 64,
  parameter int STAGES = 2,
  parameter int ROB_W  = 6,
  parameter int PRD_W  = 7
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [ROB_W-1:0] in_rob_idx,
  input  logic             in_prd_valid,
  input  logic [PRD_W-1:0] in_prd,
  output logic             wb_valid,
  input  logic             wb_ready,
  output logic [ROB_W-1:0] wb_rob_idx,
  output logic             wb_prd_valid,
  output logic [PRD_W-1:0] wb_prd,
  output logic [63:0]      wb_value,
  output logic [31:0]      wb_flags
);

  localparam int SHW = $clog2(XLEN);

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_SLL   = 4'd5,
    OP_SRL   = 4'd6,
    OP_SRA   = 4'd7,
    OP_SLT   = 4'd8,
    OP_SLTU  = 4'd9,
    OP_PASSB = 4'd10
  } op_e;

  logic adv;
  logic accept;

  // The whole pipe moves as one unit, so the only stall source is the writeback port.
  assign adv      = !wb_valid || wb_ready;
  assign in_ready = adv;
  assign accept   = in_valid && adv && !flush;

  logic [XLEN-1:0] sum;
  logic [XLEN-1:0] diff;
  logic [XLEN-1:0] res;
  logic [SHW-1:0]  shamt;
  logic            illegal;
  logic [63:0]     value_d;
  logic [31:0]     flags_d;

  always_comb begin
    sum     = in_a + in_b;
    diff    = in_a - in_b;
    shamt   = in_b[SHW-1:0];
    res     = '0;
    illegal = 1'b0;
    case (op_e'(in_op))
      OP_ADD:   res = sum;
      OP_SUB:   res = diff;
      OP_AND:   res = in_a & in_b;
      OP_OR:    res = in_a | in_b;
      OP_XOR:   res = in_a ^ in_b;
      OP_SLL:   res = in_a << shamt;
      OP_SRL:   res = in_a >> shamt;
      OP_SRA:   res = $signed(in_a) >>> shamt;
      OP_SLT:   res[0] = $signed(in_a) < $signed(in_b);
      OP_SLTU:  res[0] = in_a < in_b;
      OP_PASSB: res = in_b;
      default:  illegal = 1'b1;
    endcase
    value_d            = '0;
    value_d[XLEN-1:0]  = res;
  end

`ifdef Z480_INT_ALU_FLAGS_EN
  logic flag_z;
  logic flag_n;
  logic flag_c;
  logic flag_v;

  always_comb begin
    flag_z = (res == '0);
    flag_n = res[XLEN-1];
    flag_c = 1'b0;
    flag_v = 1'b0;
    // Carry-out of an add shows up as the wrapped sum being below an operand.
    if (op_e'(in_op) == OP_ADD) begin
      flag_c = (sum < in_a);
      flag_v = (in_a[XLEN-1] == in_b[XLEN-1]) && (sum[XLEN-1] != in_a[XLEN-1]);
    end else if (op_e'(in_op) == OP_SUB) begin
      flag_c = (in_a < in_b);
      flag_v = (in_a[XLEN-1] != in_b[XLEN-1]) && (diff[XLEN-1] != in_a[XLEN-1]);
    end
    flags_d = {illegal, 27'd0, 4'd0};
    if (!illegal) begin
      flags_d[3:0] = {flag_v, flag_c, flag_n, flag_z};
    end
  end
`else
  always_comb begin
    flags_d = {illegal, 31'd0};
  end
`endif

  logic             stg_vld   [STAGES];
  logic [63:0]      stg_val   [STAGES];
  logic [31:0]      stg_flg   [STAGES];
  logic [ROB_W-1:0] stg_rob   [STAGES];
  logic             stg_pv    [STAGES];
  logic [PRD_W-1:0] stg_prd   [STAGES];

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      logic             vld_d;
      logic [63:0]      val_d;
      logic [31:0]      flg_d;
      logic [ROB_W-1:0] rob_d;
      logic             pv_d;
      logic [PRD_W-1:0] prd_d;

      logic             vld_q;
      logic [63:0]      val_q;
      logic [31:0]      flg_q;
      logic [ROB_W-1:0] rob_q;
      logic             pv_q;
      logic [PRD_W-1:0] prd_q;

      if (gi == 0) begin : g_head
        assign vld_d = accept;
        assign val_d = value_d;
        assign flg_d = flags_d;
        assign rob_d = in_rob_idx;
        assign pv_d  = in_prd_valid;
        assign prd_d = in_prd;
      end else begin : g_tail
        assign vld_d = stg_vld[gi-1];
        assign val_d = stg_val[gi-1];
        assign flg_d = stg_flg[gi-1];
        assign rob_d = stg_rob[gi-1];
        assign pv_d  = stg_pv[gi-1];
        assign prd_d = stg_prd[gi-1];
      end

      // Bubbles move the valid bit only; payload registers change just for real uops.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          vld_q <= 1'b0;
          val_q <= '0;
          flg_q <= '0;
          rob_q <= '0;
          pv_q  <= 1'b0;
          prd_q <= '0;
        end else if (flush) begin
          vld_q <= 1'b0;
        end else if (adv) begin
          vld_q <= vld_d;
          if (vld_d) begin
            val_q <= val_d;
            flg_q <= flg_d;
            rob_q <= rob_d;
            pv_q  <= pv_d;
            prd_q <= prd_d;
          end
        end
      end

      assign stg_vld[gi] = vld_q;
      assign stg_val[gi] = val_q;
      assign stg_flg[gi] = flg_q;
      assign stg_rob[gi] = rob_q;
      assign stg_pv[gi]  = pv_q;
      assign stg_prd[gi] = prd_q;
    end
  endgenerate

  assign wb_valid     = stg_vld[STAGES-1];
  assign wb_value     = stg_val[STAGES-1];
  assign wb_flags     = stg_flg[STAGES-1];
  assign wb_rob_idx   = stg_rob[STAGES-1];
  assign wb_prd_valid = stg_pv[STAGES-1];
  assign wb_prd       = stg_prd[STAGES-1];

endmodule
